// File: rtl/axis_rr_arbiter_mux_pkg.sv
// Shared types and helpers for the round-robin AXI4-Stream arbiter/mux family.
// The helpers work on a fixed 32-bit request space so a single function serves every channel count.
package axis_rr_arbiter_mux_pkg;

  localparam int unsigned MAX_CH    = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (onehot[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  // Bits strictly above last_ptr: the requesters that outrank everyone else this round.
  function automatic logic [MAX_CH-1:0] rr_mask(input logic [MAX_IDX_W-1:0] last_ptr);
    return ~({MAX_CH{1'b1}} >> (MAX_IDX_W'(MAX_CH - 1) - last_ptr));
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester after last_ptr wins,
// wrapping modulo REQ_NUM.
module axis_rr_arbiter
  import axis_rr_arbiter_mux_pkg::*;
#(
  parameter  int unsigned REQ_NUM = 8,
  localparam int unsigned IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [REQ_NUM-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [REQ_NUM-1:0] masked;
  logic [REQ_NUM-1:0] pick;

  always_comb begin
    masked    = req & REQ_NUM'(rr_mask(MAX_IDX_W'(last_ptr)));
    // Fall back to the unmasked set when nobody sits above the pointer (wrap-around).
    pick      = (|masked) ? masked : req;
    grant     = pick & (~pick + REQ_NUM'(1));
    grant_idx = IDX_W'(onehot_to_idx(MAX_CH'(grant)));
    grant_vld = |req;
  end

endmodule

// File: rtl/axis_round_robin_arbiter_mux.sv
// Packet-aware N:1 AXI4-Stream mux with an internal round-robin arbiter and a
// one-beat registered output stage.
module axis_round_robin_arbiter_mux
  import axis_rr_arbiter_mux_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned CHANNEL_NUM = 8,
  parameter  int unsigned PACKET_MODE = 1,
  localparam int unsigned TKEEP_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned IDX_W       = $clog2(CHANNEL_NUM)
) (
  input  logic                              clk_i,
  input  logic                              arst_n_i,
  input  logic [CHANNEL_NUM-1:0]            s_axis_tvalid,
  output logic [CHANNEL_NUM-1:0]            s_axis_tready,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNEL_NUM*TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [CHANNEL_NUM-1:0]            s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [CHANNEL_NUM-1:0]            grant_o,
  output logic                              busy_o
);

  // Handshake: a beat moves on any port only in a cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, and a stalled master payload holds.

  arb_state_e state_q, state_d;

  logic [CHANNEL_NUM-1:0] grant_q;
  logic [IDX_W-1:0]       grant_idx_q;
  logic [IDX_W-1:0]       last_ptr_q;

  logic [CHANNEL_NUM-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_vld;

  logic                   out_vld_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [TKEEP_WIDTH-1:0] out_keep_q;
  logic                   out_last_q;

  logic                   sel_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [TKEEP_WIDTH-1:0] sel_keep;
  logic                   sel_last;

  logic out_free;
  logic load_grant;
  logic beat_acc;
  logic pkt_done;

  axis_rr_arbiter #(
    .REQ_NUM (CHANNEL_NUM)
  ) u_arbiter (
    .req       (s_axis_tvalid),
    .last_ptr  (last_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // AND-OR mux driven by the registered one-hot grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      sel_valid = sel_valid | (s_axis_tvalid[i] & grant_q[i]);
      sel_data  = sel_data | (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
      sel_keep  = sel_keep | (s_axis_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH] & {TKEEP_WIDTH{grant_q[i]}});
      sel_last  = sel_last | (s_axis_tlast[i] & grant_q[i]);
    end
  end

  assign out_free = !out_vld_q || m_axis_tready;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = '0;
    load_grant    = 1'b0;
    beat_acc      = 1'b0;
    pkt_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          load_grant = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        s_axis_tready = grant_q & {CHANNEL_NUM{out_free}};
        beat_acc      = sel_valid && out_free;
        if (beat_acc && ((PACKET_MODE == 0) || sel_last)) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset parks the pointer on the last channel so channel 0 wins the first round.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_ptr_q  <= IDX_W'(CHANNEL_NUM - 1);
    end else if (load_grant) begin
      grant_q     <= arb_grant;
      grant_idx_q <= arb_idx;
    end else if (pkt_done) begin
      grant_q     <= '0;
      last_ptr_q  <= grant_idx_q;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else if (beat_acc) begin
      out_vld_q  <= 1'b1;
      out_data_q <= sel_data;
      out_keep_q <= sel_keep;
      out_last_q <= sel_last;
    end else if (m_axis_tready) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q == BUSY);

  ready_onehot_a: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    $onehot0(s_axis_tready));

  out_stable_a: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (m_axis_tvalid && !m_axis_tready) |=> (m_axis_tvalid && $stable(m_axis_tdata) &&
                                          $stable(m_axis_tkeep) && $stable(m_axis_tlast)));

endmodule

// File: doc/axis_round_robin_arbiter_mux.md
# axis_round_robin_arbiter_mux

- Packet-aware AXI4-Stream N:1 multiplexer with an internal round-robin arbiter; no external select.
- Holds a grant for a whole packet, or for a single beat, depending on mode.
- Registers the output through a one-beat pipeline stage.
- Sits in front of shared stream consumers (DMA write channel, packetiser) that merge several producer streams.

## Interface
Parameters:
- DATA_WIDTH, 32: tdata width per channel; multiple of 8.
- CHANNEL_NUM, 8: number of slave channels, 2..32.
- PACKET_MODE, 1: 1 = grant held until the tlast beat is accepted; 0 = re-arbitrate after every beat.
- TKEEP_WIDTH (localparam): DATA_WIDTH/8.

Ports:
- clk_i, in, 1: single clock; all logic on the rising edge.
- arst_n_i, in, 1: reset, asynchronous, active-low.
- s_axis_tvalid, in, CHANNEL_NUM: per-channel valid.
- s_axis_tready, out, CHANNEL_NUM: per-channel ready; at most one bit set.
- s_axis_tdata, in, CHANNEL_NUM*DATA_WIDTH: channel i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep, in, CHANNEL_NUM*TKEEP_WIDTH: packed per channel, same scheme as tdata.
- s_axis_tlast, in, CHANNEL_NUM: per-channel last.
- m_axis_tvalid, out, 1: master valid.
- m_axis_tready, in, 1: master ready.
- m_axis_tdata, out, DATA_WIDTH: master data.
- m_axis_tkeep, out, TKEEP_WIDTH: master keep.
- m_axis_tlast, out, 1: master last.
- grant_o, out, CHANNEL_NUM: one-hot current grant; all zero in IDLE.
- busy_o, out, 1: high in BUSY.

## Operation
State machine, two states:
- IDLE
  - Arbiter evaluates s_axis_tvalid, starting at channel last_ptr+1 and wrapping modulo CHANNEL_NUM.
  - If any request is present: register the one-hot grant and go to BUSY.
  - If no request is present: stay in IDLE.
- BUSY
  - Granted channel only: s_axis_tready[g] = !out_vld | m_axis_tready. All other ready bits are 0.
  - A beat is accepted when s_axis_tvalid[g] & s_axis_tready[g]. Accepting a beat loads the output register with tdata, tkeep and tlast.
  - PACKET_MODE=1: accepting the tlast beat sets last_ptr=g, clears the grant and returns to IDLE.
  - PACKET_MODE=0: every accepted beat does the same.
  - If the granted channel deasserts tvalid mid-packet, the grant is held; no other channel is served.

Output register:
- m_axis_tvalid is set on accept.
- It clears on m_axis_tready when no new beat is accepted in the same cycle.
- A simultaneous drain and accept replaces the contents with the new beat; throughput is kept.
- The output holds stable while m_axis_tvalid & !m_axis_tready (AXIS rule).

Reset (asynchronous assert; deassert synchronised externally):
- state=IDLE, last_ptr=CHANNEL_NUM-1, so channel 0 wins first.
- m_axis_tvalid, m_axis_tdata, m_axis_tkeep and m_axis_tlast are 0.
- s_axis_tready, grant_o and busy_o are 0.
- Reset mid-packet drops the packet and any beat held in the output register.

## Timing
- Arbitration: 1 cycle in IDLE. tvalid first seen at cycle n gives grant_o/busy_o at n+1 and s_axis_tready at n+1 (output register free).
- Beat latency: accepted at cycle k, visible on m_axis at k+1.
- Throughput:
  - PACKET_MODE=1: one beat/cycle inside a packet, plus one idle cycle between packets.
  - PACKET_MODE=0: one beat per 2 cycles.
- s_axis_tready is combinational from m_axis_tready (no skid buffer). The downstream must not make m_axis_tready depend on s_axis_tready.
- Fairness: with all channels requesting continuously, packets are served in order 0,1,…,N-1,0. No channel waits more than CHANNEL_NUM-1 packets.
- Single-beat packet (tlast on the first beat): returns to IDLE the next cycle.

## Structure
- Package axis_rr_arbiter_mux_pkg holds:
  - state enum (IDLE, BUSY)
  - function onehot_to_idx
  - function for the rotating priority mask
- Sub-module axis_rr_arbiter: combinational rotating-priority arbiter (req, last_ptr → one-hot grant, index). Reusable by a future demux/crossbar.
- The top module holds the FSM, grant/last_ptr registers, data mux and output register.

## Test plan
- Reset then idle: all outputs 0 and stay 0 with no tvalid. Assert arst_n_i mid-packet: m_axis_tvalid drops asynchronously; channel 0 is served first afterwards.
- CHANNEL_NUM=4, PACKET_MODE=1, all channels send 3-beat packets (data = ch<<8 | beat) with m_axis_tready=1: output order ch0,ch1,ch2,ch3,ch0. One gap cycle between packets; no interleaving.
- Only ch2 requests, 4-beat packet: grant_o=4'b0100 one cycle after tvalid; beats appear on m_axis with 1-cycle latency.
- Random m_axis_tready backpressure (~50%): the m_axis payload stays stable while stalled; no beat is lost or duplicated (scoreboard per channel).
- PACKET_MODE=0, ch0 and ch1 both streaming: beats alternate ch0,ch1,ch0 at one beat per 2 cycles; tlast is forwarded unchanged.
- Granted ch1 drops tvalid mid-packet for 5 cycles while ch3 requests: ch3 is not granted until the ch1 tlast beat is accepted.
